// File: rtl/clk_en_sched_pkg.sv
// Shared types and defaults for the clock-enable scheduler.
package clk_en_sched_pkg;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/clk_en_chan.sv
// One scheduler channel: down-counter, active/shadow divisor, adopt flag, drain-done flag.
module clk_en_chan
  import clk_en_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,      // SYNC: preload counter for RUN entry
  input  logic             run,
  input  logic             drain,
  input  logic             cfg_now,   // IDLE/SYNC: config applies immediately
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] div_in,
  output logic             ce,
  output logic             pend,
  output logic             drained
);
  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] div_q, div_d, sh_q, sh_d, cnt_q, cnt_d;
  logic             pend_q, pend_d, dd_q, dd_d, ce_q, ce_d;

  // Reload value; a divisor of 0 behaves as 1.
  function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - ONE;
  endfunction

  always_comb begin
    div_d  = div_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    dd_d   = dd_q;
    ce_d   = 1'b0;
    if (cfg_load && cfg_now) begin
      div_d  = div_in;
      sh_d   = div_in;
      pend_d = 1'b0;
    end
    if (load) begin
      dd_d  = 1'b0;
      cnt_d = reload_of(div_d);
      ce_d  = (cnt_d == '0);
    end else if (run) begin
      if (cnt_q == '0) begin
        if (pend_q) begin
          div_d  = sh_q;
          pend_d = 1'b0;
        end
        cnt_d = reload_of(div_d);
      end else begin
        cnt_d = cnt_q - ONE;
      end
      // A fresh load overrides any adoption this cycle and restarts tracking.
      if (cfg_load) begin
        sh_d   = div_in;
        pend_d = 1'b1;
      end
      ce_d = (cnt_d == '0);
    end else if (drain) begin
      pend_d = 1'b0;
      if (!dd_q) begin
        if (cnt_q == '0) begin
          dd_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
          ce_d  = (cnt_d == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= ONE;
      sh_q   <= ONE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      dd_q   <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      dd_q   <= dd_d;
      ce_q   <= ce_d;
    end
  end

  assign ce      = ce_q;
  assign pend    = pend_q;
  // The drain tick is the cycle the counter sits at 0 in DRAIN; after it the counter holds 0.
  assign drained = drain && (cnt_q == '0);
endmodule

// File: rtl/clk_en_sched.sv
// Two-channel clock-enable scheduler with shadowed divisors and a drain-on-stop FSM.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             STOP,
  input  logic [DIV_W-1:0] DIV0,
  input  logic [DIV_W-1:0] DIV1,
  input  logic             CFG_LOAD,
  output logic             CE0,
  output logic             CE1,
  output logic             CFG_ACK,
  output logic             DONE,
  output logic [1:0]       STATE
);
  state_e state_q, state_d;
  logic   ack_q, ack_d, done_q, done_d, trk_q, trk_d;
  logic   pend0, pend1, drn0, drn1;
  logic   load, run, drain, cfg_now;

  assign load    = (state_q == SYNC);
  assign run     = (state_q == RUN);
  assign drain   = (state_q == DRAIN);
  assign cfg_now = (state_q == IDLE) || (state_q == SYNC);

  clk_en_chan #(.DIV_W(DIV_W)) u_chan0 (
    .clk(CLK), .rst_n(RESETN), .load(load), .run(run), .drain(drain),
    .cfg_now(cfg_now), .cfg_load(CFG_LOAD), .div_in(DIV0),
    .ce(CE0), .pend(pend0), .drained(drn0)
  );

  clk_en_chan #(.DIV_W(DIV_W)) u_chan1 (
    .clk(CLK), .rst_n(RESETN), .load(load), .run(run), .drain(drain),
    .cfg_now(cfg_now), .cfg_load(CFG_LOAD), .div_in(DIV1),
    .ce(CE1), .pend(pend1), .drained(drn1)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    trk_d   = trk_q;
    case (state_q)
      IDLE:  if (START && !STOP) state_d = SYNC;
      SYNC:  state_d = RUN;
      RUN:   if (STOP) state_d = DRAIN;
      DRAIN: if (drn0 && drn1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Ack once a tracked config has been adopted by both channels.
    if (drain) begin
      trk_d = 1'b0;
    end else if (CFG_LOAD) begin
      trk_d = 1'b1;
    end else if (trk_q && !pend0 && !pend1) begin
      ack_d = 1'b1;
      trk_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      trk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      trk_q   <= trk_d;
    end
  end

  assign CFG_ACK = ack_q;
  assign DONE    = done_q;
  assign STATE   = state_q;
endmodule
